// File: rtl/root_ctrl_pkg.sv
// Shared definitions for the root-FPGA control node: FSM states, message field
// positions, header codes and the summary message layout.
package root_ctrl_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StSummary} state_e;

  // Header codes shared with the rest of the control tree.
  localparam logic [7:0] HdrInitializeDecoding = 8'h01;
  localparam logic [7:0] HdrDecodeBlock        = 8'h02;
  localparam logic [7:0] HdrResetClock         = 8'h03;
  localparam logic [7:0] HdrSetBoundaries      = 8'h04;
  localparam logic [7:0] HdrResult             = 8'h10;

  localparam int unsigned DestMsb    = 63;
  localparam int unsigned DestLsb    = 56;
  localparam int unsigned HeaderMsb  = 55;
  localparam int unsigned HeaderLsb  = 48;
  localparam int unsigned ChildIdMsb = 47;
  localparam int unsigned ChildIdLsb = 40;
  localparam int unsigned LatencyMsb = 15;
  localparam int unsigned LatencyLsb = 0;

  localparam int unsigned FlagWaitBit      = 2;
  localparam int unsigned FlagReportAllBit = 3;

  localparam int unsigned SumTagBit     = 47;
  localparam int unsigned SumTimeoutBit = 46;
  localparam int unsigned SumMissingMsb = 31;
  localparam int unsigned SumMissingLsb = 16;

  function automatic logic [63:0] pack_summary(input logic        timeout,
                                               input logic [15:0] missing,
                                               input logic [15:0] max_latency);
    logic [63:0] msg;
    msg = '0;
    msg[HeaderMsb:HeaderLsb]         = HdrResult;
    msg[SumTagBit]                   = 1'b1;
    msg[SumTimeoutBit]               = timeout;
    msg[SumMissingMsb:SumMissingLsb] = missing;
    msg[LatencyMsb:LatencyLsb]       = max_latency;
    return msg;
  endfunction

endpackage

// File: rtl/root_result_tracker.sv
// Tracks which children have reported and the worst latency seen so far.
// Duplicate and out-of-range child IDs are ignored.
module root_result_tracker #(
  parameter int unsigned NumChildren = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_i,
  input  logic                   update_i,
  input  logic [7:0]             id_i,
  input  logic [15:0]            latency_i,
  output logic [NumChildren-1:0] seen_o,
  output logic [15:0]            max_latency_o,
  output logic                   all_seen_o
);

  logic [NumChildren-1:0] seen_q, seen_d, hit, new_bits;
  logic [15:0]            max_q, max_d;
  logic                   accept;

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NumChildren; i++) begin
      hit[i] = update_i && (id_i == 8'(i));
    end
    new_bits = hit & ~seen_q;
    accept   = |new_bits;
    seen_d   = clear_i ? '0 : (seen_q | new_bits);
    max_d    = max_q;
    if (clear_i) begin
      max_d = '0;
    end else if (accept && (latency_i > max_q)) begin
      max_d = latency_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seen_q <= '0;
      max_q  <= '0;
    end else begin
      seen_q <= seen_d;
      max_q  <= max_d;
    end
  end

  assign seen_o        = seen_q;
  assign max_latency_o = max_q;
  // Includes this cycle's update so the summary follows the final result by one cycle.
  assign all_seen_o    = &(seen_q | new_bits);

endmodule

// File: rtl/root_result_collector.sv
// Root control node: forwards CPU commands down the tree, collects one result per
// child after a waiting DECODE_BLOCK, and returns a single summary to the CPU.
module root_result_collector
  import root_ctrl_pkg::*;
#(
  parameter int unsigned CTRL_FIFO_WIDTH = 64,
  parameter int unsigned NUM_CHILDREN    = 4,
  parameter int unsigned TIMEOUT_WIDTH   = 20,
  parameter int unsigned TIMEOUT_CYCLES  = 100000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CTRL_FIFO_WIDTH-1:0] data_from_cpu,
  input  logic                       valid_from_cpu,
  output logic                       ready_from_cpu,
  output logic [CTRL_FIFO_WIDTH-1:0] data_to_fpgas,
  output logic                       valid_to_fpgas,
  input  logic                       ready_to_fpgas,
  input  logic [CTRL_FIFO_WIDTH-1:0] data_from_fpgas,
  input  logic                       valid_from_fpgas,
  output logic                       ready_from_fpgas,
  output logic [CTRL_FIFO_WIDTH-1:0] data_to_cpu,
  output logic                       valid_to_cpu,
  input  logic                       ready_to_cpu
);

  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] TimeoutLast = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                    state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0]  timer_q, timer_d;
  logic                      timeout_q, timeout_d;
  logic                      report_all_q, report_all_d;
  logic                      trk_clear, trk_update, all_seen;
  logic [NUM_CHILDREN-1:0]   seen;
  logic [15:0]               max_latency, missing;
  logic [7:0]                cpu_dest, cpu_header, up_header;
  logic                      is_bcast;

  assign cpu_dest   = data_from_cpu[DestMsb:DestLsb];
  assign cpu_header = data_from_cpu[HeaderMsb:HeaderLsb];
  assign up_header  = data_from_fpgas[HeaderMsb:HeaderLsb];
  assign is_bcast   = (cpu_header == HdrInitializeDecoding) || (cpu_header == HdrDecodeBlock) ||
                      (cpu_header == HdrResetClock);

  // Kept outside the FSM block so the tracker's all_seen feedback has no comb loop.
  assign ready_from_fpgas = (state_q == StIdle) ||
                            ((state_q == StWait) && (!report_all_q || ready_to_cpu));
  assign trk_update = (state_q == StWait) && valid_from_fpgas && ready_from_fpgas &&
                      (up_header == HdrResult);

  root_result_tracker #(
    .NumChildren(NUM_CHILDREN)
  ) u_tracker (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (trk_clear),
    .update_i     (trk_update),
    .id_i         (data_from_fpgas[ChildIdMsb:ChildIdLsb]),
    .latency_i    (data_from_fpgas[LatencyMsb:LatencyLsb]),
    .seen_o       (seen),
    .max_latency_o(max_latency),
    .all_seen_o   (all_seen)
  );

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    timeout_d      = timeout_q;
    report_all_d   = report_all_q;
    trk_clear      = 1'b0;
    ready_from_cpu = 1'b0;
    valid_to_fpgas = 1'b0;
    data_to_fpgas  = data_from_cpu;
    valid_to_cpu   = 1'b0;
    data_to_cpu    = '0;
    missing        = '0;
    missing[NUM_CHILDREN-1:0] = ~seen;

    unique case (state_q)
      StIdle: begin
        ready_from_cpu = ready_to_fpgas;
        if (cpu_dest != 8'h00) begin
          valid_to_fpgas = valid_from_cpu;
        end else if (is_bcast) begin
          valid_to_fpgas = valid_from_cpu;
          data_to_fpgas[DestMsb:DestLsb] = 8'hFF;
        end else if (cpu_header == HdrSetBoundaries) begin
          valid_to_fpgas = valid_from_cpu;
        end
        if (valid_from_cpu && ready_to_fpgas && (cpu_header == HdrDecodeBlock) &&
            data_from_cpu[FlagWaitBit]) begin
          state_d      = StWait;
          report_all_d = data_from_cpu[FlagReportAllBit];
          trk_clear    = 1'b1;
          timer_d      = '0;
          timeout_d    = 1'b0;
        end
      end
      StWait: begin
        if (report_all_q) begin
          valid_to_cpu = valid_from_fpgas;
          data_to_cpu  = data_from_fpgas;
        end
        if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
        if (all_seen) begin
          state_d   = StSummary;
          timeout_d = 1'b0;
        end else if (TimeoutEn && (timer_q == TimeoutLast)) begin
          state_d   = StSummary;
          timeout_d = 1'b1;
        end
      end
      StSummary: begin
        valid_to_cpu = 1'b1;
        data_to_cpu  = pack_summary(timeout_q, missing, max_latency);
        if (ready_to_cpu) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      timeout_q    <= 1'b0;
      report_all_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      timeout_q    <= timeout_d;
      report_all_q <= report_all_d;
    end
  end

endmodule
